csa19_resolve: RTL and testbench
================================

Name: csa19_resolve

Overview:
- Carry-propagate back end for the 19-bit half-adder carry-save row.
- Takes a redundant (carry, sum) vector pair and resolves it to a plain binary value: result = sum + (carry << 1).
- Addition is done serially, CHUNK bits per cycle, with a registered inter-chunk carry. This keeps the adder narrow and off the critical path.
- Sits between the CSA row and any downstream consumer that needs binary operands. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 19, width of the in_carry and in_sum vectors.
- CHUNK, 5, bits resolved per ADD cycle. Legal range 1..WIDTH+2.
- RW (derived, localparam), WIDTH+2, result width. Covers the worst-case sum of arbitrary input vectors.
- NCHUNK (derived, localparam), ceil(RW/CHUNK), number of ADD cycles. Equals 5 at the defaults.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input pair is valid.
- in_ready  out  1  block can accept a pair.
- in_carry  in  WIDTH  carry vector; bit i has weight 2^(i+1).
- in_sum  in  WIDTH  sum vector; bit i has weight 2^i.
- out_valid  out  1  out_result is valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  RW  binary result.
- out_err  out  1  only present with CSA_CHECK_EN.

Behaviour:
- Reset (synchronous, active-high; clock and reset named clk and reset):
  - state=IDLE, in_ready=1, out_valid=0, out_result=0, out_err=0.
  - Chunk index and chunk carry flop cleared.
  - Reset asserted mid-ADD or in DONE abandons the operation. No output handshake occurs for it.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register opA = zero-extended in_sum and opB = zero-extended in_carry shifted left by 1, both RW bits.
  - On the same edge: clear the chunk carry, set idx=0, go to ADD. in_ready drops on the next cycle.
- ADD:
  - in_ready=0, out_valid=0.
  - Each cycle, add opA chunk idx + opB chunk idx + chunk carry. Write the CHUNK-bit sum into the result register chunk idx and register the carry-out.
  - The top chunk may be partial (RW not a multiple of CHUNK): only the RW-valid bits are written, and its carry-out is discarded. It is always 0 because RW is sized for the worst case.
  - When idx==NCHUNK-1, go to DONE.
- DONE:
  - out_valid=1; out_result holds stable until the handshake.
  - On out_valid&&out_ready, go to IDLE. out_valid drops and in_ready rises on the next cycle.
  - No same-cycle result-handoff/new-accept overlap.
- Latency:
  - Accept edge at cycle 0; out_valid is first high in cycle NCHUNK+1.
  - Minimum issue interval is NCHUNK+2 cycles with out_ready tied high.
  - Defaults: result visible in cycle 6, interval 7.
- Boundaries:
  - Input changes while not in IDLE are ignored.
  - out_ready low stalls indefinitely in DONE with the result held.
  - CHUNK=RW gives NCHUNK=1: single ADD cycle.
  - in_valid held high across DONE must not cause a second accept until IDLE.
  - out_result is the registered result; it changes only in ADD and on reset.

Optional Feature:
- Macro: CSA_CHECK_EN.
- Defined:
  - Adds port out_err (out, 1).
  - On accept, registers err = |(in_carry & in_sum). A half-adder row can never set carry and sum at the same bit position, so this flags a corrupt or non-HA pair.
  - out_err is valid while out_valid=1 and cleared on reset and on each new accept.
  - The result is still computed normally.
- Not defined: no out_err port, no check logic; behaviour otherwise identical.

Test Plan:
- Reset mid-ADD: accept any pair, assert reset in the 3rd ADD cycle -> next cycle state IDLE, in_ready=1, out_valid=0, out_result=0; no spurious out_valid afterwards.
- HA pair from a=0x7FFFF, b=0x00001: in_sum=0x7FFFE, in_carry=0x00001 -> out_valid in cycle 6, out_result=0x080000 (carry ripples across all chunks).
- Max HA pair from a=b=0x7FFFF: in_sum=0x00000, in_carry=0x7FFFF -> out_result=0x0FFFFE; with CSA_CHECK_EN, out_err=0.
- Illegal pair in_carry=0x7FFFF, in_sum=0x7FFFF -> out_result=0x17FFFD (21 bits, top bit set); with CSA_CHECK_EN, out_err=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_result stable and in_ready=0 throughout, with in_valid held high and a different pair presented. Raise out_ready -> handshake, IDLE next cycle, then the new pair is accepted.
- Parameter sweep CHUNK=21 and CHUNK=1 with a=0x12345, b=0x54321 HA pair -> out_result=0x066666; first out_valid in cycle 2 and cycle 22 respectively.

Source files
------------

// File: rtl/csa19_resolve.sv
// csa19_resolve: serial carry-propagate back end for a half-adder carry-save row.
// Resolves result = sum + (carry << 1), CHUNK bits per ADD cycle, with valid/ready on both sides.
// Optional macro CSA_CHECK_EN adds out_err, which flags pairs with carry and sum set at the same bit.
module csa19_resolve #(
   parameter int unsigned WIDTH = 19,
   parameter int unsigned CHUNK = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_carry,
   input  logic [WIDTH-1:0] in_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH+1:0] out_result
`ifdef CSA_CHECK_EN
   ,
   output logic             out_err
`endif
);

   localparam int unsigned RW     = WIDTH + 2;
   localparam int unsigned NCHUNK = (RW + CHUNK - 1) / CHUNK;
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LastIdx = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e          state_q, state_d;
   logic [RW-1:0]   op_a_q, op_b_q;
   logic [RW-1:0]   res_q, res_d;
   logic [IW-1:0]   idx_q;
   logic            carry_q, carry_d;
   logic [RW-1:0]   a_shift, b_shift, chunk_mask, chunk_data;
   logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
   logic            c_out;
   logic            accept, last;
`ifdef CSA_CHECK_EN
   logic            err_q;
`endif

   assign accept = in_valid && in_ready;
   assign last   = (idx_q == LastIdx);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one ADD cycle per chunk, hold in DONE until the consumer takes the result.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StAdd;
         StAdd:   if (last) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
   end

   // Chunk adder; bits shifted past RW fall off, so a partial top chunk only writes valid bits.
   always_comb begin
      a_shift    = op_a_q >> (CHUNK * 32'(idx_q));
      b_shift    = op_b_q >> (CHUNK * 32'(idx_q));
      a_chunk    = a_shift[CHUNK-1:0];
      b_chunk    = b_shift[CHUNK-1:0];
      {c_out, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      chunk_mask = RW'({CHUNK{1'b1}}) << (CHUNK * 32'(idx_q));
      chunk_data = RW'(s_chunk) << (CHUNK * 32'(idx_q));
      res_d      = (res_q & ~chunk_mask) | chunk_data;
      // Top-chunk carry-out is always zero given RW; drop it rather than carry it forward.
      carry_d    = last ? 1'b0 : c_out;
   end

   // Operand capture on accept and per-chunk result/carry update while adding.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
      end else if (accept) begin
         op_a_q  <= RW'(in_sum);
         op_b_q  <= RW'({in_carry, 1'b0});
         idx_q   <= '0;
         carry_q <= 1'b0;
      end else if (state_q == StAdd) begin
         res_q   <= res_d;
         idx_q   <= idx_q + IW'(1);
         carry_q <= carry_d;
      end
   end

   assign out_result = res_q;

`ifdef CSA_CHECK_EN
   // A half-adder row never sets carry and sum at one position; latch the violation on accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= |(in_carry & in_sum);
      end
   end

   assign out_err = err_q;
`endif

endmodule

// File: tb/tb_csa19_resolve.sv
// Directed bench for csa19_resolve with a result scoreboard plus CHUNK=21 / CHUNK=1 instances.
module tb_csa19_resolve;

   localparam int unsigned W  = 19;
   localparam int unsigned RW = 21;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_carry = '0;
   logic [W-1:0]  in_sum = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [RW-1:0] out_result;

   logic          s_valid = 1'b0;
   logic [W-1:0]  s_carry = '0;
   logic [W-1:0]  s_sum = '0;
   logic          s1_in_ready, s1_out_valid, s2_in_ready, s2_out_valid;
   logic [RW-1:0] s1_result, s2_result;
`ifdef CSA_CHECK_EN
   logic          out_err, s1_err, s2_err;
`endif

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   typedef struct packed {
      logic [RW-1:0] res;
      logic          err;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [W-1:0]  a, b;

   always #5 clk = ~clk;

   csa19_resolve #(.WIDTH(19), .CHUNK(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_carry(in_carry), .in_sum(in_sum), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result)
`ifdef CSA_CHECK_EN
      , .out_err(out_err)
`endif
   );

   csa19_resolve #(.WIDTH(19), .CHUNK(21)) dut_c21 (
      .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s1_in_ready),
      .in_carry(s_carry), .in_sum(s_sum), .out_valid(s1_out_valid),
      .out_ready(1'b1), .out_result(s1_result)
`ifdef CSA_CHECK_EN
      , .out_err(s1_err)
`endif
   );

   csa19_resolve #(.WIDTH(19), .CHUNK(1)) dut_c1 (
      .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s2_in_ready),
      .in_carry(s_carry), .in_sum(s_sum), .out_valid(s2_out_valid),
      .out_ready(1'b1), .out_result(s2_result)
`ifdef CSA_CHECK_EN
      , .out_err(s2_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one pair from IDLE, queue its expected result, and wait for out_valid.
   task automatic send(input logic [W-1:0] s, input logic [W-1:0] c,
                       input logic [RW-1:0] exp_res, input string tag);
      int   k;
      exp_t e;
      check({tag, "_in_ready"}, in_ready, 1);
      e.res = exp_res;
      e.err = |(s & c);
      sb.push_back(e);
      in_sum   = s;
      in_carry = c;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      k = 1;
      while (!out_valid && k < 64) begin
         step();
         k++;
      end
      check({tag, "_latency"}, k, 6);
   endtask

   // Scoreboard: compare each result on the cycle its handshake completes.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         n_total++;
         assert (sb.size() > 0) n_pass++;
         else begin
            n_fail++;
            $error("FAIL sb_spurious: got out_valid with result 0x%0h, expected none pending",
                   out_result);
         end
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("sb_result", out_result, mon_e.res);
`ifdef CSA_CHECK_EN
            check("sb_err", out_err, mon_e.err);
`endif
         end
      end
   end

   initial begin
      int k, lat1, lat2;
      logic [RW-1:0] r1, r2;

      // Reset state
      reset = 1'b1;
      repeat (3) step();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
`ifdef CSA_CHECK_EN
      check("rst_out_err", out_err, 0);
`endif
      reset = 1'b0;
      step();

      // Reset in the 3rd ADD cycle abandons the operation
      in_sum   = 19'h12345;
      in_carry = 19'h00000;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("mid_accepted", in_ready, 0);
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_in_ready", in_ready, 1);
      check("mid_out_valid", out_valid, 0);
      check("mid_out_result", out_result, 0);
      repeat (10) step();
      check("mid_no_output", out_valid, 0);

      // Directed vectors, out_ready high
      send(19'h7FFFE, 19'h00001, 21'h080000, "ha_ripple");
      step();
      send(19'h00000, 19'h7FFFF, 21'h0FFFFE, "ha_max");
      step();
      send(19'h7FFFF, 19'h7FFFF, 21'h17FFFD, "illegal");
      step();

      // Random half-adder pairs: resolved value must equal a + b
      for (int i = 0; i < 4; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         send(a ^ b, a & b, RW'(a) + RW'(b), "ha_rand");
         step();
      end

      // Backpressure with a different pair held on the input
      out_ready = 1'b0;
      send(19'h0ABCD, 19'h01010, 21'h00CBED, "bp_first");
      mon_e.res = 21'h011511;
      mon_e.err = 1'b0;
      sb.push_back(mon_e);
      in_sum   = 19'h11111;
      in_carry = 19'h00200;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_hold_result", out_result, 21'h00CBED);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      step();
      check("bp_idle_ready", in_ready, 1);
      check("bp_idle_valid", out_valid, 0);
      step();
      in_valid = 1'b0;
      check("bp_second_accept", in_ready, 0);
      k = 1;
      while (!out_valid && k < 64) begin
         step();
         k++;
      end
      check("bp_second_latency", k, 6);
      step();

      // CHUNK sweep: 21 -> single ADD cycle, 1 -> 21 ADD cycles
      a = 19'h12345;
      b = 19'h54321;
      s_sum   = a ^ b;
      s_carry = a & b;
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      lat1 = 0;
      lat2 = 0;
      r1 = '0;
      r2 = '0;
      k = 1;
      while (k < 40 && (lat1 == 0 || lat2 == 0)) begin
         if (s1_out_valid && lat1 == 0) begin
            lat1 = k;
            r1 = s1_result;
         end
         if (s2_out_valid && lat2 == 0) begin
            lat2 = k;
            r2 = s2_result;
         end
         step();
         k++;
      end
      check("c21_latency", lat1, 2);
      check("c21_result", r1, RW'(a) + RW'(b));
      check("c1_latency", lat2, 22);
      check("c1_result", r2, RW'(a) + RW'(b));

      repeat (3) step();
      check("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
